// File: rtl/cache_bus_arbiter_pkg.sv
// rtl/cache_bus_arbiter_pkg.sv - cache line format constants and arbiter state type
package cache_bus_arbiter_pkg;

   // Line address covers byte address bits 31:4; one transfer moves a full 128-bit line
   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int SEL_W  = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - two-master Wishbone arbiter between L1 caches and L2
module cache_bus_arbiter
   import cache_bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   // icache master
   input  logic              i_cyc,
   input  logic              i_stb,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_adr,
   input  logic [DATA_W-1:0] i_dat_m,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [DATA_W-1:0] i_dat_s,
   output logic              i_ack,
   output logic              i_rty,
   // dcache master
   input  logic              d_cyc,
   input  logic              d_stb,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_adr,
   input  logic [DATA_W-1:0] d_dat_m,
   input  logic [SEL_W-1:0]  d_sel,
   output logic [DATA_W-1:0] d_dat_s,
   output logic              d_ack,
   output logic              d_rty,
   // L2 slave
   output logic              l2_cyc,
   output logic              l2_stb,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_adr,
   output logic [DATA_W-1:0] l2_dat_m,
   output logic [SEL_W-1:0]  l2_sel,
   input  logic [DATA_W-1:0] l2_dat_s,
   input  logic              l2_ack,
   input  logic              l2_rty
);

   arb_state_t state;
   arb_state_t state_next;

   // A response terminates the granted cycle; responses during reset are swallowed
   logic done;
   assign done = l2_ack || l2_rty;

   // State register: grant decision is registered so a new request reaches L2 one cycle later
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state: dcache has fixed priority; grants end on ack/retry or master abort
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (d_cyc && d_stb)      state_next = ST_GRANT_D;
            else if (i_cyc && i_stb) state_next = ST_GRANT_I;
         end
         ST_GRANT_I: if (done || !i_cyc) state_next = ST_IDLE;
         ST_GRANT_D: if (done || !d_cyc) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Output steering: forward the granted master's request and route responses back to it only
   always_comb begin
      l2_cyc   = 1'b0;
      l2_stb   = 1'b0;
      l2_we    = 1'b0;
      l2_adr   = '0;
      l2_dat_m = '0;
      l2_sel   = '0;
      i_ack    = 1'b0;
      i_rty    = 1'b0;
      d_ack    = 1'b0;
      d_rty    = 1'b0;
      // read data is only meaningful alongside an ack, so both masters see it unconditionally
      i_dat_s  = l2_dat_s;
      d_dat_s  = l2_dat_s;
      case (state)
         ST_GRANT_I: begin
            l2_cyc   = i_cyc;
            l2_stb   = i_stb;
            l2_we    = i_we;
            l2_adr   = i_adr;
            l2_dat_m = i_dat_m;
            l2_sel   = i_sel;
            i_ack    = l2_ack && !rst;
            i_rty    = l2_rty && !rst;
         end
         ST_GRANT_D: begin
            l2_cyc   = d_cyc;
            l2_stb   = d_stb;
            l2_we    = d_we;
            l2_adr   = d_adr;
            l2_dat_m = d_dat_m;
            l2_sel   = d_sel;
            d_ack    = l2_ack && !rst;
            d_rty    = l2_rty && !rst;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;
   import cache_bus_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_cyc, i_stb, i_we;
   logic [ADDR_W-1:0] i_adr;
   logic [DATA_W-1:0] i_dat_m;
   logic [SEL_W-1:0]  i_sel;
   logic [DATA_W-1:0] i_dat_s;
   logic              i_ack, i_rty;
   logic              d_cyc, d_stb, d_we;
   logic [ADDR_W-1:0] d_adr;
   logic [DATA_W-1:0] d_dat_m;
   logic [SEL_W-1:0]  d_sel;
   logic [DATA_W-1:0] d_dat_s;
   logic              d_ack, d_rty;
   logic              l2_cyc, l2_stb, l2_we;
   logic [ADDR_W-1:0] l2_adr;
   logic [DATA_W-1:0] l2_dat_m;
   logic [SEL_W-1:0]  l2_sel;
   logic [DATA_W-1:0] l2_dat_s;
   logic              l2_ack, l2_rty;

   cache_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_m(i_dat_m), .i_sel(i_sel),
      .i_dat_s(i_dat_s), .i_ack(i_ack), .i_rty(i_rty),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_m(d_dat_m), .d_sel(d_sel),
      .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty),
      .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_adr(l2_adr), .l2_dat_m(l2_dat_m),
      .l2_sel(l2_sel), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack), .l2_rty(l2_rty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: who holds the bus this cycle (0 nobody, 1 icache, 2 dcache)
   int owner   = 0;
   bit started = 1'b0;
   bit i_fin, d_fin;

   always @(posedge clk) begin
      i_fin = (owner == 1) && (l2_ack || l2_rty) && !rst;
      d_fin = (owner == 2) && (l2_ack || l2_rty) && !rst;
      if (rst)
         owner = 0;
      else if (owner == 0)
         owner = (d_cyc && d_stb) ? 2 : (i_cyc && i_stb) ? 1 : 0;
      else if (owner == 1 && (l2_ack || l2_rty || !i_cyc))
         owner = 0;
      else if (owner == 2 && (l2_ack || l2_rty || !d_cyc))
         owner = 0;
      started = 1'b1;
   end

   // Every cycle: compare all DUT outputs to what the current owner implies
   always @(negedge clk) begin
      if (started) begin
         logic              e_cyc, e_stb, e_we, e_ia, e_ir, e_da, e_dr;
         logic [ADDR_W-1:0] e_adr;
         logic [DATA_W-1:0] e_dat;
         logic [SEL_W-1:0]  e_sel;
         e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
         e_ia = 0; e_ir = 0; e_da = 0; e_dr = 0;
         if (owner == 1) begin
            e_cyc = i_cyc; e_stb = i_stb; e_we = i_we; e_adr = i_adr; e_dat = i_dat_m; e_sel = i_sel;
            e_ia = l2_ack & ~rst; e_ir = l2_rty & ~rst;
            chk("i_dat_s", i_dat_s, l2_dat_s);
         end else if (owner == 2) begin
            e_cyc = d_cyc; e_stb = d_stb; e_we = d_we; e_adr = d_adr; e_dat = d_dat_m; e_sel = d_sel;
            e_da = l2_ack & ~rst; e_dr = l2_rty & ~rst;
            chk("d_dat_s", d_dat_s, l2_dat_s);
         end
         chk("l2_cyc", l2_cyc, e_cyc);
         chk("l2_stb", l2_stb, e_stb);
         chk("l2_we", l2_we, e_we);
         chk("l2_adr", l2_adr, e_adr);
         chk("l2_dat_m", l2_dat_m, e_dat);
         chk("l2_sel", l2_sel, e_sel);
         chk("i_ack", i_ack, e_ia);
         chk("i_rty", i_rty, e_ir);
         chk("d_ack", d_ack, e_da);
         chk("d_rty", d_rty, e_dr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [DATA_W-1:0] pat_a, pat_w;

   initial begin
      rst = 1; l2_ack = 0; l2_rty = 0; l2_dat_s = '0;
      i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_m = '0; i_sel = '0;
      d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_m = '0; d_sel = '0;
      pat_a = {8{16'hAAAA}};
      pat_w = {8{16'h1234}};
      nxt(); nxt();
      @(negedge clk);
      chk("reset_l2_cyc", l2_cyc, 0);
      chk("reset_i_ack", i_ack, 0);
      nxt();
      rst = 0;

      // 1: icache-only read, acked after a few wait states
      nxt();
      i_cyc = 1; i_stb = 1; i_adr = 28'h0000010;
      @(negedge clk); chk("t1_grant_registered", l2_cyc, 0);
      nxt();
      @(negedge clk); chk("t1_l2_adr", l2_adr, 28'h0000010); chk("t1_l2_cyc", l2_cyc, 1);
      nxt(); nxt();
      l2_ack = 1; l2_dat_s = pat_a;
      @(negedge clk); chk("t1_i_ack", i_ack, 1); chk("t1_i_dat_s", i_dat_s, pat_a); chk("t1_d_ack", d_ack, 0);
      nxt();
      l2_ack = 0; i_cyc = 0; i_stb = 0; l2_dat_s = '0;
      @(negedge clk); chk("t1_idle", l2_cyc, 0);

      // 2: dcache full-line write
      nxt();
      d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 28'h00000FF; d_sel = 16'hFFFF; d_dat_m = pat_w;
      nxt();
      @(negedge clk); chk("t2_l2_we", l2_we, 1); chk("t2_l2_sel", l2_sel, 16'hFFFF); chk("t2_l2_dat_m", l2_dat_m, pat_w);
      nxt();
      l2_ack = 1;
      @(negedge clk); chk("t2_d_ack", d_ack, 1);
      nxt();
      l2_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;

      // 3/4: simultaneous requests, dcache first, one turnaround cycle, then icache while d re-requests
      nxt();
      d_cyc = 1; d_stb = 1; d_adr = 28'h0000ABC; i_cyc = 1; i_stb = 1; i_adr = 28'h0000123;
      nxt();
      @(negedge clk); chk("t3_d_first", l2_adr, 28'h0000ABC);
      nxt();
      l2_ack = 1;
      @(negedge clk); chk("t3_d_ack", d_ack, 1); chk("t3_i_ack_held", i_ack, 0);
      nxt();
      l2_ack = 0; d_cyc = 0; d_stb = 0;
      @(negedge clk); chk("t3_turnaround", l2_cyc, 0);
      nxt();
      d_cyc = 1; d_stb = 1; d_adr = 28'h0000777;
      @(negedge clk); chk("t3_i_granted", l2_adr, 28'h0000123);
      nxt();
      l2_ack = 1;
      @(negedge clk); chk("t4_i_ack", i_ack, 1); chk("t4_d_ack", d_ack, 0); chk("t4_adr_held", l2_adr, 28'h0000123);
      nxt();
      l2_ack = 0; i_cyc = 0; i_stb = 0;
      nxt();
      @(negedge clk); chk("t4_d_granted", l2_adr, 28'h0000777);

      // 5: reset in the middle of the dcache grant, then a late ack
      nxt();
      rst = 1;
      nxt();
      rst = 0; l2_ack = 1; d_cyc = 0; d_stb = 0;
      @(negedge clk); chk("t5_l2_cyc", l2_cyc, 0); chk("t5_d_ack", d_ack, 0);
      nxt();
      l2_ack = 0;

      // 6: retry to icache, then re-grant of the held request
      nxt();
      i_cyc = 1; i_stb = 1; i_adr = 28'h0000042;
      nxt();
      l2_rty = 1;
      @(negedge clk); chk("t6_i_rty", i_rty, 1);
      nxt();
      l2_rty = 0;
      @(negedge clk); chk("t6_idle", l2_cyc, 0);
      nxt();
      @(negedge clk); chk("t6_regrant", l2_cyc, 1);
      l2_ack = 0;
      nxt();
      l2_ack = 1;
      nxt();
      l2_ack = 0; i_cyc = 0; i_stb = 0;
      nxt();

      // randomized traffic: masters hold requests until answered, occasional aborts and resets
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst = ($urandom_range(63) == 0);
         if (i_cyc && (i_fin || $urandom_range(31) == 0)) begin
            i_cyc = 0; i_stb = 0;
         end else if (!i_cyc && $urandom_range(2) == 0) begin
            i_cyc = 1; i_stb = 1; i_we = $urandom_range(1); i_adr = ADDR_W'($urandom);
            i_dat_m = rnd128(); i_sel = SEL_W'($urandom);
         end
         if (d_cyc && (d_fin || $urandom_range(31) == 0)) begin
            d_cyc = 0; d_stb = 0;
         end else if (!d_cyc && $urandom_range(2) == 0) begin
            d_cyc = 1; d_stb = 1; d_we = $urandom_range(1); d_adr = ADDR_W'($urandom);
            d_dat_m = rnd128(); d_sel = SEL_W'($urandom);
         end
         l2_ack   = ($urandom_range(3) == 0);
         l2_rty   = !l2_ack && ($urandom_range(15) == 0);
         l2_dat_s = rnd128();
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter between the split L1 caches and the unified L2 cache.
- Upstream masters are the instruction cache port (ibus side) and the data cache port (dbus side) of the pipelined core.
- It grants one master at a time and forwards that master's cycle to the L2 slave port. It routes the slave's ACK/RTY/read data back to the granted master only.

Parameters:
- ADDR_W, 28, line address width (byte address bits 31:4).
- DATA_W, 128, line data width.
- SEL_W, 16, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_cyc, i_stb, i_we  in  1 each  icache master request.
- i_adr  in  ADDR_W  icache line address.
- i_dat_m  in  DATA_W  icache write data.
- i_sel  in  SEL_W  icache byte selects.
- i_dat_s  out  DATA_W  read data to icache.
- i_ack, i_rty  out  1 each  acknowledge / retry to icache.
- d_cyc, d_stb, d_we, d_adr, d_dat_m, d_sel  in  same widths as the icache inputs  dcache master request.
- d_dat_s, d_ack, d_rty  out  same widths as the icache outputs  responses to dcache.
- l2_cyc, l2_stb, l2_we  out  1 each  forwarded request.
- l2_adr  out  ADDR_W  forwarded address.
- l2_dat_m  out  DATA_W  forwarded write data.
- l2_sel  out  SEL_W  forwarded byte selects.
- l2_dat_s  in  DATA_W  L2 read data.
- l2_ack, l2_rty  in  1 each  L2 acknowledge / retry.

Behaviour:
- FSM states are IDLE, GRANT_I and GRANT_D. Reset state is IDLE.
- IDLE:
  - If d_cyc&d_stb, go to GRANT_D. This applies even when icache also requests: dcache has fixed priority.
  - Else if i_cyc&i_stb, go to GRANT_I.
  - Else stay in IDLE.
- The grant decision is registered. A request first seen in cycle N reaches the L2 port in cycle N+1.
- GRANT_x, output routing:
  - l2_cyc/stb/we/adr/dat_m/sel are driven combinationally from master x's inputs.
  - l2_ack, l2_rty and l2_dat_s are routed combinationally to x_ack, x_rty and x_dat_s.
  - The other master's ack and rty are held at 0. Its dat_s is also driven from l2_dat_s; this is don't-care.
- GRANT_x, exit conditions:
  - On l2_ack=1 or l2_rty=1, return to IDLE at the next edge. The master drops its request after ACK.
  - If master x deasserts cyc before ACK (abort), return to IDLE next edge.
- Back-to-back transfers: one IDLE cycle separates consecutive grants (bus turnaround).
  - Example: dcache finishes, icache pending → icache granted in the cycle after IDLE.
- IDLE outputs: l2_cyc=l2_stb=l2_we=0, l2_adr=0, l2_dat_m=0, l2_sel=0, i_ack=i_rty=d_ack=d_rty=0.
- Reset values: all outputs as in IDLE.
- Reset mid-transfer: forces IDLE at that edge and drops l2_cyc/stb in the following cycle. An ACK arriving during reset is discarded.
- Spurious l2_ack in IDLE is ignored; no ack is routed to either master.
- Request inputs are not latched; masters must hold them stable until ACK (standard Wishbone classic).
- No starvation guard: the icache may wait while the dcache issues continuous requests. This is acceptable because the core stalls fetch while a memory-stage miss is in flight.

Decomposition:
- Shared package: typedef for the arbiter state enum, and ADDR_W/DATA_W/SEL_W constants for the cache line format.
- Single module; no sub-module needed.
- An optional 2:1 response/request steering mux may reuse the existing generic mux2.

Test Plan:
1. icache-only read: i_cyc=i_stb=1, i_adr=0x0000010, L2 acks 3 cycles later with l2_dat_s=0xAAAA…
   → l2_adr=0x0000010 from cycle 1; i_ack=1 with i_dat_s=0xAAAA…; d_ack stays 0; IDLE after ACK.
2. dcache write: d_we=1, d_adr=0x00000FF, d_sel=0xFFFF, d_dat_m=0x1234…
   → l2_we=1, l2_sel=0xFFFF, l2_dat_m=0x1234…; d_ack on l2_ack.
3. Simultaneous i and d requests in the same cycle → dcache granted first. After d_ack there is one IDLE cycle, then icache is granted and receives i_ack; total two L2 transactions.
4. Request arrives while other master is granted (d pending during GRANT_I) → l2 signals stay on icache values until ACK; d_ack=0 throughout.
5. rst asserted mid GRANT_D before l2_ack → next cycle l2_cyc=0, d_ack=0, state IDLE. A late l2_ack produces no master ack.
6. l2_rty=1 in GRANT_I → i_rty=1 for that cycle, return to IDLE. Re-request is then re-granted.
